// File: rtl/vec8_pack_buffer.sv
// -----------------------------------------------------------------------------
// vec8_pack_buffer
//   Upstream feeder for the FindMin stage. Serial DATA_W-bit elements arrive
//   over a valid/ready handshake and are packed, NUM at a time, into one of two
//   banks (ping-pong). A full bank is copied into `numbers` and presented to
//   FindMin with a level `start`; it is held until FindMin pulses `done`, then
//   the bank is released and one idle cycle (GAP) follows so FindMin sees
//   `start` drop before the next vector.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   clear         synchronous flush of both banks and the read FSM
//   in_valid      in_data is valid
//   in_ready      an element can be accepted this cycle
//   in_data       element value
//   numbers       packed vector, element i at [DATA_W*i +: DATA_W]
//   start         level request to FindMin, high while `numbers` is valid
//   done          FindMin finished the current vector
//   banks_full    number of banks currently FULL or BUSY (0..2)
// -----------------------------------------------------------------------------
module vec8_pack_buffer #(
  parameter int DATA_W = 16,
  parameter int NUM    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  output logic [DATA_W*NUM-1:0] numbers,
  output logic                  start,
  input  logic                  done,
  output logic [1:0]            banks_full
);

  localparam int CNT_W = $clog2(NUM);

  typedef enum logic [1:0] {
    B_EMPTY   = 2'd0,
    B_FILLING = 2'd1,
    B_FULL    = 2'd2,
    B_BUSY    = 2'd3
  } bank_state_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2
  } rd_state_t;

  bank_state_t          bank_st     [2];
  bank_state_t          bank_st_nxt [2];
  logic                 fill_ptr, fill_ptr_nxt;
  logic                 rd_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0]     elem_cnt, elem_cnt_nxt;
  rd_state_t            state, state_nxt;
  logic                 start_nxt;
  logic                 load_numbers;
  logic [1:0]           banks_full_nxt;
  logic                 accept;
  logic [DATA_W-1:0]    mem [2][NUM];
  logic [DATA_W*NUM-1:0] rd_vec;

  // The fill bank can take data while it is not yet handed to the read side.
  // Gating with rst_n keeps in_ready low for the whole reset interval.
  assign in_ready = rst_n && !clear &&
                    ((bank_st[fill_ptr] == B_EMPTY) || (bank_st[fill_ptr] == B_FILLING));
  assign accept   = in_valid && in_ready;

  // Flatten the bank being read into the FindMin bus layout.
  always_comb begin
    rd_vec = '0;
    for (int i = 0; i < NUM; i++) begin
      rd_vec[i*DATA_W +: DATA_W] = mem[rd_ptr][i];
    end
  end

  // Next-state logic for both the write side and the read FSM. The write side
  // only ever touches an EMPTY/FILLING bank and the read side only a FULL/BUSY
  // one, so both may update bank_st_nxt in the same cycle without conflict.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    for (int b = 0; b < 2; b++) begin
      bank_st_nxt[b] = bank_st[b];
    end
    fill_ptr_nxt = fill_ptr;
    rd_ptr_nxt   = rd_ptr;
    elem_cnt_nxt = elem_cnt;
    state_nxt    = state;
    start_nxt    = start;
    load_numbers = 1'b0;

    // Write side
    if (accept) begin
      if (elem_cnt == CNT_W'(NUM - 1)) begin
        bank_st_nxt[fill_ptr] = B_FULL;
        elem_cnt_nxt          = '0;
        fill_ptr_nxt          = ~fill_ptr;
      end else begin
        bank_st_nxt[fill_ptr] = B_FILLING;
        elem_cnt_nxt          = elem_cnt + CNT_W'(1);
      end
    end

    // Read FSM
    case (state)
      S_IDLE: begin
        start_nxt = 1'b0;
        if (bank_st[rd_ptr] == B_FULL) begin
          bank_st_nxt[rd_ptr] = B_BUSY;
          load_numbers        = 1'b1;
          start_nxt           = 1'b1;
          state_nxt           = S_RUN;
        end
      end
      S_RUN: begin
        if (done) begin
          start_nxt           = 1'b0;
          bank_st_nxt[rd_ptr] = B_EMPTY;
          rd_ptr_nxt          = ~rd_ptr;
          state_nxt           = S_GAP;
        end
      end
      S_GAP: begin
        // One guaranteed low cycle on start before the next load.
        start_nxt = 1'b0;
        state_nxt = S_IDLE;
      end
      default: begin
        start_nxt = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase

    // Flush overrides everything; numbers is deliberately left untouched.
    if (clear) begin
      for (int b = 0; b < 2; b++) begin
        bank_st_nxt[b] = B_EMPTY;
      end
      fill_ptr_nxt = 1'b0;
      rd_ptr_nxt   = 1'b0;
      elem_cnt_nxt = '0;
      state_nxt    = S_IDLE;
      start_nxt    = 1'b0;
      load_numbers = 1'b0;
    end

    // Occupancy follows the bank states that are about to be registered.
    banks_full_nxt = {1'b0, (bank_st_nxt[0] == B_FULL) || (bank_st_nxt[0] == B_BUSY)}
                   + {1'b0, (bank_st_nxt[1] == B_FULL) || (bank_st_nxt[1] == B_BUSY)};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_st[0] <= B_EMPTY;
      bank_st[1] <= B_EMPTY;
      fill_ptr   <= 1'b0;
      rd_ptr     <= 1'b0;
      elem_cnt   <= '0;
      state      <= S_IDLE;
      start      <= 1'b0;
      numbers    <= '0;
      banks_full <= 2'd0;
    end else begin
      bank_st[0] <= bank_st_nxt[0];
      bank_st[1] <= bank_st_nxt[1];
      fill_ptr   <= fill_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      elem_cnt   <= elem_cnt_nxt;
      state      <= state_nxt;
      start      <= start_nxt;
      banks_full <= banks_full_nxt;
      if (load_numbers) begin
        numbers <= rd_vec;
      end
    end
  end

  // NOTE: bank storage has no reset; a bank is only read after all NUM slots
  // were written, so its power-up contents are never observed.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[fill_ptr][elem_cnt] <= in_data;
    end
  end

endmodule

// File: tb/tb_vec8_pack_buffer.sv
// -----------------------------------------------------------------------------
// tb_vec8_pack_buffer
//   Self-checking bench for vec8_pack_buffer. Every accepted element is fed to
//   a small packing model; each completed group of 8 is pushed to a queue and
//   popped when the DUT raises start, then compared with `numbers`.
// -----------------------------------------------------------------------------
module tb_vec8_pack_buffer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clear;
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  in_data;
  logic [127:0] numbers;
  logic         start;
  logic         done;
  logic [1:0]   banks_full;

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] exp_q[$];
  logic [127:0] exp_vec;
  int           exp_cnt;
  int           n_pushed = 0;
  int           n_seen   = 0;

  logic start_q      = 1'b0;
  int   low_run      = 0;
  bit   gap_check_en = 1'b0;
  bit   seen_vec     = 1'b0;

  vec8_pack_buffer #(.DATA_W(16), .NUM(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .numbers    (numbers),
    .start      (start),
    .done       (done),
    .banks_full (banks_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_vec = '0;
    exp_cnt = 0;
  endtask

  task automatic model_accept(input logic [15:0] d);
    exp_vec[exp_cnt*16 +: 16] = d;
    exp_cnt++;
    if (exp_cnt == 8) begin
      exp_q.push_back(exp_vec);
      n_pushed++;
      model_reset();
    end
  endtask

  // Drive one element until accepted (bounded), then idle for `idle` cycles.
  task automatic send_elem(input logic [15:0] d, input int idle);
    bit sent = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int k = 0; k < 200 && !sent; k++) begin
      @(negedge clk);
      if (in_ready) begin
        tick();
        model_accept(d);
        sent = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!sent) check("send_timeout", 0, 1);
    repeat (idle) tick();
  endtask

  task automatic pulse_done();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic wait_start();
    bit got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (start) got = 1'b1;
    end
    if (!got) check("start_timeout", 0, 1);
  endtask

  // Scoreboard monitor: compare on each rising edge of start.
  always @(negedge clk) begin
    if (start && !start_q) begin
      if (gap_check_en && seen_vec) check("start_low_gap", 128'(low_run >= 2), 1);
      if (exp_q.size() == 0) begin
        check("unexpected_vector", 0, 1);
      end else begin
        check("vector", numbers, exp_q.pop_front());
      end
      n_seen++;
      seen_vec = 1'b1;
    end
    if (!start) low_run++;
    else        low_run = 0;
    start_q = start;
  end

  logic [15:0] vals [24];
  logic [127:0] held;
  int changes;
  int n_acc;
  int idx;
  bit acc;

  initial begin
    rst_n    = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    done     = 1'b0;
    model_reset();

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_numbers", numbers, 0);
    check("rst_start", start, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_banks_full", banks_full, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", in_ready, 1);

    // Basic pack
    send_elem(16'h0010, 0); send_elem(16'h0005, 0);
    send_elem(16'h0020, 0); send_elem(16'h0003, 0);
    send_elem(16'h0100, 0); send_elem(16'h0007, 0);
    send_elem(16'h0009, 0); send_elem(16'h0002, 0);
    check("lat_start_low", start, 0);
    check("lat_banks_full", banks_full, 1);
    tick();
    check("lat_start_high", start, 1);
    check("basic_numbers", numbers, 128'h0002_0009_0007_0100_0003_0020_0005_0010);
    held    = numbers;
    changes = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (numbers !== held || start !== 1'b1) changes++;
    end
    check("hold_stable", changes, 0);
    #1;
    pulse_done();
    check("done_start_low", start, 0);
    check("done_banks_full", banks_full, 0);
    repeat (2) tick();

    // Ping-pong backpressure
    for (int i = 0; i < 24; i++) vals[i] = 16'(16'hC000 + i * 16'h0101);
    gap_check_en = 1'b1;
    seen_vec     = 1'b0;
    n_acc = 0;
    idx   = 0;
    for (int c = 0; c < 24; c++) begin
      in_valid = 1'b1;
      in_data  = vals[idx];
      @(negedge clk);
      acc = in_ready;
      tick();
      if (acc) begin
        model_accept(vals[idx]);
        n_acc++;
        idx++;
      end
    end
    check("pp_accepted", n_acc, 16);
    check("pp_in_ready_low", in_ready, 0);
    check("pp_banks_full", banks_full, 2);
    pulse_done();
    check("pp_in_ready_back", in_ready, 1);
    for (int i = 16; i < 24; i++) send_elem(vals[i], 0);
    pulse_done();
    wait_start();
    #1;
    pulse_done();
    check("pp_final_banks_full", banks_full, 0);
    repeat (2) tick();
    gap_check_en = 1'b0;

    // Gapped input
    for (int i = 1; i <= 8; i++) send_elem(16'(i), 1);
    wait_start();
    check("gapped_numbers", numbers, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    #1;
    pulse_done();
    repeat (2) tick();

    // Spurious done while idle
    pulse_done();
    check("spur_start", start, 0);
    check("spur_banks_full", banks_full, 0);
    check("spur_in_ready", in_ready, 1);
    for (int i = 0; i < 8; i++) send_elem(16'(16'h0300 + i), 0);
    wait_start();
    #1;
    pulse_done();
    repeat (2) tick();

    // Clear mid-fill
    for (int i = 0; i < 5; i++) send_elem(16'(16'h0B00 + i), 0);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'hDEAD;
    @(negedge clk);
    check("clear_in_ready", in_ready, 0);
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    model_reset();
    check("clear_banks_full", banks_full, 0);
    for (int i = 0; i < 8; i++) send_elem(16'(16'h00A0 + i), 0);
    wait_start();
    check("clear_numbers", numbers, 128'h00A7_00A6_00A5_00A4_00A3_00A2_00A1_00A0);
    #1;
    pulse_done();
    repeat (2) tick();

    // Async reset during RUN
    for (int i = 0; i < 8; i++) send_elem(16'(16'h0E00 + i), 0);
    wait_start();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_start", start, 0);
    check("arst_numbers", numbers, 0);
    check("arst_banks_full", banks_full, 0);
    check("arst_in_ready", in_ready, 0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    send_elem(16'h0010, 0); send_elem(16'h0005, 0);
    send_elem(16'h0020, 0); send_elem(16'h0003, 0);
    send_elem(16'h0100, 0); send_elem(16'h0007, 0);
    send_elem(16'h0009, 0); send_elem(16'h0002, 0);
    tick();
    check("arst_refill_start", start, 1);
    check("arst_refill_numbers", numbers, 128'h0002_0009_0007_0100_0003_0020_0005_0010);
    @(negedge clk);
    #1;
    pulse_done();
    repeat (2) tick();

    check("queue_empty", exp_q.size(), 0);
    check("vectors_seen", n_seen, n_pushed);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
